data_memory_hs: RTL

Parametrised single-port data memory with a valid/ready request/response handshake, configurable wait-state latency, byte-enable writes and out-of-range error reporting. It replaces the fixed 32x32 negedge data memory in the processor datapath. It lets the load/store path stall on slow memory and lets one block serve several word widths and depths.

---
 rtl/data_memory_hs.sv | 118 +++++++++++
 1 files changed

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - single-port data memory with valid/ready handshake,
// wait states, byte-enable writes and out-of-range error reporting.
module data_memory_hs #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [DATA_W-1:0]     i_req_wdata,
  input  logic [DATA_W/8-1:0]   i_req_be,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      WAIT_INIT = 8'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [7:0]        r_wait_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  // Contents start at zero and are deliberately outside the reset domain.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  logic              w_in_range;
  logic              w_access;
  logic [IDX_W-1:0]  w_idx;

  assign w_in_range = ({1'b0, r_addr} < DEPTH_V);
  assign w_access   = (r_state == S_WAIT) && (r_wait_cnt == 8'd0);
  assign w_idx      = r_addr[IDX_W-1:0];

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write    <= i_req_write;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_be       <= i_req_be;
            r_wait_cnt <= WAIT_INIT;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt != 8'd0) begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end else begin
            r_state <= S_RESP;
            if (!w_in_range) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end else begin
              r_err   <= 1'b0;
              r_rdata <= r_write ? '0 : r_mem[w_idx];
            end
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // An async reset forces r_state to IDLE, so a pending write never commits.
  always_ff @(posedge i_clk) begin
    if (w_access && r_write && w_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
